packed_acc_drain_18: RTL and testbench

Consumer end of the 1x8 packed DSP MAC accumulator.
- Accepts one packed accumulator word (4 signed lanes of 10+HEADROOM bits) over a valid/ready handshake.
- Unpacks the lanes and requantizes each one: arithmetic right shift, round-half-up, saturate to int8, optional ReLU.
- Streams the 4 results out one lane per handshake, ahead of the output feature-map write path.

---
 rtl/packed_acc_drain_18_pkg.sv | 30 +++
 rtl/packed_acc_drain_18_lane_requant.sv | 43 ++++
 rtl/packed_acc_drain_18.sv | 140 ++++++++++++++
 tb/tb_packed_acc_drain_18.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/packed_acc_drain_18_pkg.sv
// Shared widths, lane ordering and FSM encoding for the packed accumulator drain.
package acc18_pkg;

  localparam int HEADROOM   = 4;
  localparam int LANE_W     = 10 + HEADROOM;
  localparam int NUM_LANES  = 4;
  localparam int IN_W       = LANE_W * NUM_LANES;
  localparam int OUT_W      = 8;
  localparam int SHIFT_W    = 4;
  localparam int LANE_IDX_W = 2;

  // Lane order inside the packed word (pixel x weight).
  localparam logic [LANE_IDX_W-1:0] LANE_P0W0 = 2'd0;
  localparam logic [LANE_IDX_W-1:0] LANE_P1W0 = 2'd1;
  localparam logic [LANE_IDX_W-1:0] LANE_P0W1 = 2'd2;
  localparam logic [LANE_IDX_W-1:0] LANE_P1W1 = 2'd3;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  function automatic logic signed [LANE_W-1:0] lane_slice(
    input logic [IN_W-1:0]       word,
    input logic [LANE_IDX_W-1:0] idx
  );
    return signed'(word[int'(idx)*LANE_W +: LANE_W]);
  endfunction

endpackage

// File: rtl/packed_acc_drain_18_lane_requant.sv
// Per-lane requantizer: arithmetic right shift with round-half-up,
// saturation to int8 and optional ReLU. Purely combinational.
module lane_requant
  import acc18_pkg::*;
(
  input  logic signed [LANE_W-1:0]  x,
  input  logic        [SHIFT_W-1:0] shift,
  input  logic                      relu,
  output logic signed [OUT_W-1:0]   y
);

  localparam logic [SHIFT_W-1:0]   S_MAX  = SHIFT_W'(LANE_W - 1);
  localparam logic signed [LANE_W:0] SAT_HI = (LANE_W+1)'(127);
  localparam logic signed [LANE_W:0] SAT_LO = -(LANE_W+1)'(128);

  logic        [SHIFT_W-1:0] s;
  logic signed [LANE_W:0]    x_ext;
  logic signed [LANE_W:0]    rnd;
  logic signed [LANE_W:0]    shifted;
  logic signed [OUT_W-1:0]   y_sat;

  always_comb begin
    s     = (shift > S_MAX) ? S_MAX : shift;
    x_ext = {x[LANE_W-1], x};
    rnd   = '0;
    // One extra bit keeps the rounding add from overflowing at the lane extremes.
    if (s != '0) begin
      rnd = signed'({{LANE_W{1'b0}}, 1'b1} << (s - SHIFT_W'(1)));
    end
    shifted = (x_ext + rnd) >>> s;

    if (shifted > SAT_HI) begin
      y_sat = 8'sd127;
    end else if (shifted < SAT_LO) begin
      y_sat = -8'sd128;
    end else begin
      y_sat = signed'(shifted[OUT_W-1:0]);
    end

    y = (relu && y_sat[OUT_W-1]) ? '0 : y_sat;
  end

endmodule

// File: rtl/packed_acc_drain_18.sv
// Drains one packed 4-lane accumulator word per input handshake and streams
// the requantized int8 lane results out one per output handshake.
module packed_acc_drain_18
  import acc18_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IN_W-1:0]       in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SHIFT_W-1:0]    cfg_shift,
  input  logic                  cfg_relu,
  output logic [OUT_W-1:0]      out_data,
  output logic [LANE_IDX_W-1:0] out_lane,
  output logic                  out_last,
  output logic                  out_valid,
  input  logic                  out_ready
);

  state_e state_q, state_d;

  logic [IN_W-1:0]       word_q, word_d;
  logic [SHIFT_W-1:0]    shift_q, shift_d;
  logic                  relu_q, relu_d;
  logic [OUT_W-1:0]      out_data_q, out_data_d;
  logic [LANE_IDX_W-1:0] out_lane_q, out_lane_d;
  logic                  out_last_q, out_last_d;
  logic                  out_valid_q, out_valid_d;

  logic                  out_hs;
  logic                  last_hs;
  logic                  in_hs;
  logic [LANE_IDX_W-1:0] nxt_lane;

  logic signed [LANE_W-1:0] rq_x;
  logic [SHIFT_W-1:0]       rq_shift;
  logic                     rq_relu;
  logic signed [OUT_W-1:0]  rq_y;

  assign out_hs   = out_valid_q & out_ready;
  assign last_hs  = out_hs & out_last_q;
  // Accepting on the lane-3 handshake keeps back-to-back words bubble-free.
  assign in_ready = (state_q == IDLE) | last_hs;
  assign in_hs    = in_valid & in_ready;
  assign nxt_lane = out_lane_q + LANE_IDX_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_hs) state_d = EMIT;
      EMIT:    if (last_hs && !in_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A new word is requantized straight from the input so lane 0 is ready one cycle later.
  always_comb begin
    if (in_hs) begin
      rq_x     = lane_slice(in_data, LANE_P0W0);
      rq_shift = cfg_shift;
      rq_relu  = cfg_relu;
    end else begin
      rq_x     = lane_slice(word_q, nxt_lane);
      rq_shift = shift_q;
      rq_relu  = relu_q;
    end
  end

  lane_requant u_requant (
    .x     (rq_x),
    .shift (rq_shift),
    .relu  (rq_relu),
    .y     (rq_y)
  );

  always_comb begin
    word_d      = word_q;
    shift_d     = shift_q;
    relu_d      = relu_q;
    out_data_d  = out_data_q;
    out_lane_d  = out_lane_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q;

    if (in_hs) begin
      word_d      = in_data;
      shift_d     = cfg_shift;
      relu_d      = cfg_relu;
      out_data_d  = rq_y;
      out_lane_d  = LANE_P0W0;
      out_last_d  = 1'b0;
      out_valid_d = 1'b1;
    end else if (out_hs) begin
      if (out_last_q) begin
        out_data_d  = '0;
        out_lane_d  = '0;
        out_last_d  = 1'b0;
        out_valid_d = 1'b0;
      end else begin
        out_data_d  = rq_y;
        out_lane_d  = nxt_lane;
        out_last_d  = (nxt_lane == LANE_P1W1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_q      <= '0;
      shift_q     <= '0;
      relu_q      <= 1'b0;
      out_data_q  <= '0;
      out_lane_q  <= '0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      word_q      <= word_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      out_data_q  <= out_data_d;
      out_lane_q  <= out_lane_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_lane  = out_lane_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_packed_acc_drain_18.sv
// Table-driven bench with an output scoreboard for packed_acc_drain_18.
module tb_packed_acc_drain_18;
  import acc18_pkg::*;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [IN_W-1:0]       in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [SHIFT_W-1:0]    cfg_shift;
  logic                  cfg_relu;
  logic [OUT_W-1:0]      out_data;
  logic [LANE_IDX_W-1:0] out_lane;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int x[4];
    int sh;
    int relu;
    int y[4];
  } vec_t;
  vec_t vecs[7];

  typedef struct packed {
    logic [7:0] d;
    logic [1:0] lane;
    logic       last;
  } exp_t;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  packed_acc_drain_18 dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .cfg_shift (cfg_shift),
    .cfg_relu  (cfg_relu),
    .out_data  (out_data),
    .out_lane  (out_lane),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input int x0, input int x1, input int x2, input int x3,
                         input int sh, input int r,
                         input int y0, input int y1, input int y2, input int y3);
    vecs[i].x[0] = x0; vecs[i].x[1] = x1; vecs[i].x[2] = x2; vecs[i].x[3] = x3;
    vecs[i].sh = sh;   vecs[i].relu = r;
    vecs[i].y[0] = y0; vecs[i].y[1] = y1; vecs[i].y[2] = y2; vecs[i].y[3] = y3;
  endtask

  function automatic logic [IN_W-1:0] pack(input int i);
    logic [IN_W-1:0] w;
    w = '0;
    for (int k = 0; k < NUM_LANES; k++) w[k*LANE_W +: LANE_W] = LANE_W'(vecs[i].x[k]);
    return w;
  endfunction

  // Scoreboard: compare each accepted output against the front of the queue.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got lane %0d data %0d expected no output", out_lane, $signed(out_data));
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_data", int'($signed(out_data)), int'($signed(e.d)));
        check("sb_lane", int'(out_lane), int'(e.lane));
        check("sb_last", int'(out_last), int'(e.last));
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the input handshake edge.
  task automatic send_word(input int idx);
    bit got;
    got       = 0;
    in_data   = pack(idx);
    cfg_shift = SHIFT_W'(vecs[idx].sh);
    cfg_relu  = vecs[idx].relu[0];
    in_valid  = 1'b1;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1;
        for (int k = 0; k < NUM_LANES; k++) begin
          exp_t e;
          e.d    = 8'(vecs[idx].y[k]);
          e.lane = 2'(k);
          e.last = (k == NUM_LANES - 1);
          exp_q.push_back(e);
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!got) begin
      check("in_handshake_timeout", 0, 1);
    end else begin
      check("latency_valid", int'(out_valid), 1);
      check("latency_lane", int'(out_lane), 0);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 100; n++) begin
      if (exp_q.size() == 0 && !out_valid) break;
      @(posedge clk);
      #1;
    end
    check("drain_pending", exp_q.size(), 0);
    check("drain_valid", int'(out_valid), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [OUT_W-1:0] hold_d;
    bit seen;

    set_vec(0,  100, -100,  8191, -8192,  0, 0,  100, -100, 127, -128);
    set_vec(1,    6,    5,    -6,    -5,  2, 0,    2,    1,  -1,   -1);
    set_vec(2,  100, -100,  8191, -8192,  2, 0,   25,  -25, 127, -128);
    set_vec(3, 8191, -8192,   -3,  4096, 15, 1,    1,    0,   0,    1);
    set_vec(4, -129,  128,  -128,   127,  0, 1,    0,  127,   0,  127);
    set_vec(5,    1,   -1,     3,    -3,  1, 0,    1,    0,   2,   -1);
    set_vec(6, 2040, -2056,   24,   -24,  4, 0,  127, -128,   2,   -1);

    reset     = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    cfg_shift = '0;
    cfg_relu  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_lane", int'(out_lane), 0);
    check("rst_out_last", int'(out_last), 0);
    check("rst_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      send_word(i);
      drain();
    end

    // Backpressure on lane 1 with cfg churn and a stray input word.
    send_word(2);
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (out_valid && out_lane == 2'd1) seen = 1;
      else begin @(posedge clk); #1; end
    end
    check("bp_reach_lane1", int'(seen), 1);
    out_ready = 1'b0;
    hold_d    = out_data;
    in_data   = pack(0);
    in_valid  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      cfg_shift = (c % 2 == 0) ? 4'd0 : 4'd9;
      cfg_relu  = ~cfg_relu;
      @(negedge clk);
      check("bp_valid", int'(out_valid), 1);
      check("bp_data", int'(out_data), int'(hold_d));
      check("bp_lane", int'(out_lane), 1);
      check("bp_in_ready", int'(in_ready), 0);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Back-to-back words: eight outputs without a bubble.
    send_word(0);
    fork
      send_word(1);
      begin
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          check("b2b_valid", int'(out_valid), 1);
          check("b2b_in_ready", int'(in_ready), int'(out_lane == 2'd3));
        end
      end
    join
    drain();

    // Reset during lane 2 discards the word.
    send_word(5);
    seen = 0;
    for (int n = 0; n < 20 && !seen; n++) begin
      if (out_valid && out_lane == 2'd2) seen = 1;
      else begin @(posedge clk); #1; end
    end
    check("rst_mid_reach_lane2", int'(seen), 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("rst_mid_valid", int'(out_valid), 0);
    check("rst_mid_data", int'(out_data), 0);
    check("rst_mid_lane", int'(out_lane), 0);
    check("rst_mid_last", int'(out_last), 0);
    exp_q.delete();
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid_in_ready", int'(in_ready), 1);
    @(posedge clk);
    #1;
    send_word(6);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
